// File: rtl/uart_tx_arbiter_if.sv
// Requester and supervisor-side signals of the UART message arbiter.
// The arbiter takes the slave modport; the requesters plus supervisor take the master modport.
interface uart_tx_arbiter_if #(
   parameter int NUM_REQ = 4
);
   logic [NUM_REQ-1:0]    i_req;
   logic [NUM_REQ*88-1:0] i_reqData;
   logic [NUM_REQ*8-1:0]  i_reqLength;
   logic [NUM_REQ-1:0]    o_grant;
   logic [NUM_REQ-1:0]    o_reqDone;
   logic [NUM_REQ-1:0]    o_reqError;
   logic                  o_busy;
   logic                  o_txBegin;
   logic [87:0]           o_txData;
   logic [7:0]            o_txDataLength;
   logic                  i_txBusy;
   logic                  i_txDone;

   modport slave (
      input  i_req, i_reqData, i_reqLength, i_txBusy, i_txDone,
      output o_grant, o_reqDone, o_reqError, o_busy, o_txBegin, o_txData, o_txDataLength
   );

   modport master (
      output i_req, i_reqData, i_reqLength, i_txBusy, i_txDone,
      input  o_grant, o_reqDone, o_reqError, o_busy, o_txBegin, o_txData, o_txDataLength
   );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx_supervisor message channel among NUM_REQ requesters.
// state    | meaning
// S_IDLE   | waiting for a request while the supervisor is not busy
// S_WAIT   | supervisor owns the granted message; waiting for done or timeout
// S_FINISH | one-cycle gap so the supervisor returns to idle before the next issue
module uart_tx_arbiter #(
   parameter int NUM_REQ        = 4,
   parameter int TIMEOUT_CYCLES = 1000000
) (
   input logic             i_clock,
   input logic             i_reset,
   uart_tx_arbiter_if.slave bus
);
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   localparam int PW = $clog2(NUM_REQ);
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
   localparam logic [PW-1:0] LAST_RST = PW'(NUM_REQ - 1);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_FINISH} state_t;

   state_t             state_q, state_d;
   logic [PW-1:0]      last_q, last_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [NUM_REQ-1:0] grant_q, grant_d;
   logic [NUM_REQ-1:0] done_q, done_d;
   logic [NUM_REQ-1:0] err_q, err_d;
   logic               begin_q, begin_d;
   logic [87:0]        data_q, data_d;
   logic [7:0]         len_q, len_d;

   logic               win_found;
   logic [PW-1:0]      win_idx;
   logic [7:0]         win_len;
   logic [87:0]        win_data;
   logic               len_ok;

   // Walk offsets from farthest to nearest so the nearest requester after last_q wins.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      for (int i = NUM_REQ; i >= 1; i--) begin
         if (bus.i_req[(int'(last_q) + i) % NUM_REQ]) begin
            win_found = 1'b1;
            win_idx   = PW'((int'(last_q) + i) % NUM_REQ);
         end
      end
   end

   assign win_len  = bus.i_reqLength[int'(win_idx)*8 +: 8];
   assign win_data = bus.i_reqData[int'(win_idx)*88 +: 88];
   assign len_ok   = (win_len != 8'd0) && (win_len <= 8'd11);

   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      cnt_d   = cnt_q;
      grant_d = grant_q;
      done_d  = '0;
      err_d   = '0;
      begin_d = 1'b0;
      data_d  = data_q;
      len_d   = len_q;
      case (state_q)
         S_IDLE: begin
            if (!bus.i_txBusy && win_found) begin
               last_d = win_idx;
               if (len_ok) begin
                  begin_d = 1'b1;
                  grant_d = NUM_REQ'(1) << win_idx;
                  data_d  = win_data;
                  len_d   = win_len;
                  cnt_d   = '0;
                  state_d = S_WAIT;
               end else begin
                  err_d = NUM_REQ'(1) << win_idx;
               end
            end
         end
         S_WAIT: begin
            cnt_d = cnt_q + 1'b1;
            if (bus.i_txDone) begin
               done_d  = grant_q;
               grant_d = '0;
               state_d = S_FINISH;
            end else if (cnt_q == CNT_LAST) begin
               err_d   = grant_q;
               grant_d = '0;
               state_d = S_FINISH;
            end
         end
         S_FINISH: state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         state_q <= S_IDLE;
         last_q  <= LAST_RST;
         cnt_q   <= '0;
         grant_q <= '0;
         done_q  <= '0;
         err_q   <= '0;
         begin_q <= 1'b0;
         data_q  <= '0;
         len_q   <= '0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         cnt_q   <= cnt_d;
         grant_q <= grant_d;
         done_q  <= done_d;
         err_q   <= err_d;
         begin_q <= begin_d;
         data_q  <= data_d;
         len_q   <= len_d;
      end
   end

   assign bus.o_grant        = grant_q;
   assign bus.o_reqDone      = done_q;
   assign bus.o_reqError     = err_q;
   assign bus.o_busy         = (state_q != S_IDLE);
   assign bus.o_txBegin      = begin_q;
   assign bus.o_txData       = data_q;
   assign bus.o_txDataLength = len_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized and directed bench for uart_tx_arbiter with a transaction-level model
// of round-robin arbitration and a simple supervisor responder.
module tb_uart_tx_arbiter;
   localparam int N  = 4;
   localparam int TO = 20;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   uart_tx_arbiter_if #(.NUM_REQ(N)) ifc ();

   uart_tx_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(TO)) dut (
      .i_clock (clk),
      .i_reset (rst),
      .bus     (ifc)
   );

   int n_checks = 0;
   int n_errors = 0;

   logic [N-1:0] pend;
   logic [87:0]  rdata [N];
   logic [7:0]   rlen  [N];

   int           m_owner, m_last, m_age, m_hold;
   logic [7:0]   m_len;
   logic [N-1:0] req_s;
   logic         busy_s, done_s, rst_s;

   bit           sup_busy, sup_hang, sup_hang_cfg;
   int           sup_rem;
   logic [7:0]   sup_bytes [$];

   int n_grant [N];
   int n_done  [N];
   int n_err   [N];
   int glog [$];
   int posts, withdraws;

   task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [N-1:0] onehot(input int w);
      logic [N-1:0] v;
      v = '0;
      v[w] = 1'b1;
      return v;
   endfunction

   function automatic int rr(input logic [N-1:0] r, input int last);
      for (int i = 1; i <= N; i++)
         if (r[(last + i) % N]) return (last + i) % N;
      return -1;
   endfunction

   function automatic int total(input int which);
      int s = 0;
      for (int k = 0; k < N; k++) s += (which == 0) ? n_done[k] : n_err[k];
      return s;
   endfunction

   task automatic apply();
      ifc.i_req = pend;
      for (int k = 0; k < N; k++) begin
         ifc.i_reqData[k*88 +: 88] = rdata[k];
         ifc.i_reqLength[k*8 +: 8] = rlen[k];
      end
   endtask

   task automatic post(input int k, input logic [7:0] len, input logic [87:0] data);
      rdata[k] = data;
      rlen[k]  = len;
      pend[k]  = 1'b1;
      posts++;
      apply();
   endtask

   function automatic logic [87:0] rand_data();
      logic [95:0] t;
      t = {$urandom, $urandom, $urandom};
      return t[87:0];
   endfunction

   task automatic monitor();
      logic [N-1:0] e_done, e_err, e_grant;
      bit elig, fin, bad;
      int w;
      if (rst_s) begin
         chk("rst_grant", ifc.o_grant, '0);
         chk("rst_done", ifc.o_reqDone, '0);
         chk("rst_error", ifc.o_reqError, '0);
         chk("rst_busy", ifc.o_busy, 0);
         chk("rst_begin", ifc.o_txBegin, 0);
         chk("rst_data", ifc.o_txData, '0);
         chk("rst_len", ifc.o_txDataLength, '0);
         m_owner = -1; m_last = N - 1; m_hold = 0;
         return;
      end
      elig = (m_owner < 0) && (m_hold == 0) && !busy_s && (req_s != '0);
      if (m_hold > 0) m_hold--;
      fin = 0; e_done = '0; e_err = '0;
      if (m_owner >= 0) begin
         m_age++;
         if (done_s) begin e_done = onehot(m_owner); fin = 1; end
         else if (m_age == TO) begin e_err = onehot(m_owner); fin = 1; end
         e_grant = fin ? '0 : onehot(m_owner);
         chk("done", ifc.o_reqDone, e_done);
         chk("error", ifc.o_reqError, e_err);
         chk("grant", ifc.o_grant, e_grant);
         chk("begin_width", ifc.o_txBegin, 0);
         chk("len_hold", ifc.o_txDataLength, m_len);
         if (fin) begin
            if (done_s) begin
               n_done[m_owner]++;
               chk("byte_count", sup_bytes.size(), m_len);
               for (int i = 0; i < int'(m_len) && i < sup_bytes.size(); i++)
                  chk("byte", sup_bytes[i], rdata[m_owner][87-8*i -: 8]);
            end else begin
               n_err[m_owner]++;
            end
            pend[m_owner] = 1'b0;
            m_owner = -1;
            m_hold = 1;
         end
      end else begin
         w = elig ? rr(req_s, m_last) : -1;
         bad = (w >= 0) && ((rlen[w] == 8'd0) || (rlen[w] > 8'd11));
         chk("begin", ifc.o_txBegin, (w >= 0) && !bad);
         chk("grant_idle", ifc.o_grant, ((w >= 0) && !bad) ? onehot(w) : '0);
         chk("done_idle", ifc.o_reqDone, '0);
         chk("error_idle", ifc.o_reqError, bad ? onehot(w) : '0);
         if (w >= 0) begin
            m_last = w;
            if (bad) begin
               n_err[w]++;
               pend[w] = 1'b0;
            end else begin
               m_owner = w; m_age = 0; m_len = rlen[w];
               n_grant[w]++;
               glog.push_back(w);
               chk("tx_data", ifc.o_txData, rdata[w]);
               chk("tx_len", ifc.o_txDataLength, rlen[w]);
            end
         end
      end
      chk("busy", ifc.o_busy, (m_owner >= 0) || fin);
   endtask

   task automatic supervisor();
      logic [87:0] td;
      ifc.i_txDone = 1'b0;
      if (ifc.o_txBegin && !sup_busy) begin
         td = ifc.o_txData;
         sup_bytes.delete();
         for (int i = 0; i < int'(ifc.o_txDataLength) && i < 11; i++)
            sup_bytes.push_back(td[87-8*i -: 8]);
         sup_hang = sup_hang_cfg;
         sup_rem  = sup_hang_cfg ? 40 : int'(ifc.o_txDataLength) + 1;
         sup_busy = 1;
      end else if (sup_busy) begin
         sup_rem--;
         if (sup_rem <= 0) begin
            sup_busy = 0;
            if (!sup_hang) ifc.i_txDone = 1'b1;
         end
      end
      ifc.i_txBusy = sup_busy;
   endtask

   task automatic tick();
      @(posedge clk);
      req_s  = ifc.i_req;
      busy_s = ifc.i_txBusy;
      done_s = ifc.i_txDone;
      rst_s  = rst;
      #1;
      monitor();
      @(negedge clk);
      supervisor();
      apply();
   endtask

   task automatic wait_quiet(input string tag, input int budget);
      int c = 0;
      bit quiet;
      quiet = 0;
      while (c < budget) begin
         if (pend == '0 && m_owner < 0 && !sup_busy && m_hold == 0) begin
            quiet = 1;
            break;
         end
         tick();
         c++;
      end
      chk(tag, quiet, 1);
   endtask

   task automatic wait_owner(input int k, input string tag);
      int c = 0;
      while (m_owner != k && c < 50) begin tick(); c++; end
      chk(tag, (m_owner == k), 1);
   endtask

   task automatic pulse_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   int d0, e0, g3;

   initial begin
      pend = '0;
      for (int k = 0; k < N; k++) begin rdata[k] = '0; rlen[k] = '0; end
      ifc.i_txBusy = 1'b0;
      ifc.i_txDone = 1'b0;
      sup_busy = 0; sup_hang = 0; sup_hang_cfg = 0; sup_rem = 0;
      m_owner = -1; m_last = N - 1; m_age = 0; m_hold = 0; m_len = '0;
      posts = 0; withdraws = 0;
      apply();

      repeat (3) tick();
      rst = 1'b0;

      // single request, bytes 0x41 0x42 0x43
      post(0, 8'd3, {24'h414243, 64'h0});
      tick();
      chk("single_latency", (m_owner == 0), 1);
      wait_quiet("single_quiet", 60);
      chk("single_done", n_done[0], 1);

      // contention from a fresh pointer
      pulse_reset();
      glog.delete();
      for (int k = 0; k < N; k++) post(k, 8'd1, rand_data());
      wait_quiet("cont_quiet", 120);
      post(0, 8'd1, rand_data());
      post(2, 8'd1, rand_data());
      wait_quiet("cont2_quiet", 60);
      chk("cont_count", glog.size(), 6);
      if (glog.size() == 6) begin
         chk("cont_o0", glog[0], 0);
         chk("cont_o1", glog[1], 1);
         chk("cont_o2", glog[2], 2);
         chk("cont_o3", glog[3], 3);
         chk("cont_o4", glog[4], 0);
         chk("cont_o5", glog[5], 2);
      end

      // bad lengths
      glog.delete();
      e0 = n_err[1];
      post(1, 8'd0, rand_data());
      wait_quiet("bad0_quiet", 20);
      post(1, 8'd12, rand_data());
      wait_quiet("bad12_quiet", 20);
      chk("bad_errors", n_err[1] - e0, 2);
      chk("bad_no_begin", glog.size(), 0);

      // timeout while supervisor stays busy; req2 waits for busy to drop
      e0 = n_err[0];
      d0 = n_done[2];
      sup_hang_cfg = 1;
      post(0, 8'd4, rand_data());
      wait_owner(0, "to_granted");
      tick();
      sup_hang_cfg = 0;
      repeat (2) tick();
      post(2, 8'd2, rand_data());
      wait_quiet("to_quiet", 150);
      chk("to_error", n_err[0] - e0, 1);
      chk("to_req2_done", n_done[2] - d0, 1);

      // reset in the middle of a 5-byte message
      d0 = n_done[1];
      post(1, 8'd5, rand_data());
      wait_owner(1, "rst_granted");
      repeat (2) tick();
      rst = 1'b1;
      pend[1] = 1'b0;
      post(0, 8'd2, rand_data());
      post(3, 8'd2, rand_data());
      tick();
      rst = 1'b0;
      glog.delete();
      wait_quiet("rst_quiet", 120);
      chk("rst_no_done", n_done[1] - d0, 0);
      chk("rst_count", glog.size(), 2);
      if (glog.size() == 2) begin
         chk("rst_first", glog[0], 0);
         chk("rst_second", glog[1], 3);
      end

      // withdrawal while another message is active
      g3 = n_grant[3];
      e0 = n_err[3];
      d0 = n_done[3];
      post(0, 8'd6, rand_data());
      wait_owner(0, "wd_granted");
      post(3, 8'd2, rand_data());
      repeat (2) tick();
      pend[3] = 1'b0;
      withdraws++;
      apply();
      wait_quiet("wd_quiet", 60);
      chk("wd_no_grant", n_grant[3] - g3, 0);
      chk("wd_no_pulse", (n_err[3] - e0) + (n_done[3] - d0), 0);

      // randomized traffic
      posts = 0; withdraws = 0;
      d0 = total(0);
      e0 = total(1);
      for (int c = 0; c < 600; c++) begin
         tick();
         for (int k = 0; k < N; k++) begin
            if (!pend[k] && $urandom_range(0, 7) == 0) begin
               if ($urandom_range(0, 9) == 0)
                  post(k, ($urandom_range(0, 1) == 0) ? 8'd0 : 8'($urandom_range(12, 255)), rand_data());
               else
                  post(k, 8'($urandom_range(1, 11)), rand_data());
            end else if (pend[k] && m_owner != k && $urandom_range(0, 63) == 0) begin
               pend[k] = 1'b0;
               withdraws++;
               apply();
            end
         end
      end
      wait_quiet("rand_quiet", 400);
      chk("rand_accounting", (total(0) - d0) + (total(1) - e0), posts - withdraws);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
